mem_arbiter: RTL and testbench

//  Shares one multi-cycle unified memory between the instruction-fetch port and the data port of the CPU.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the fetch and data ports.
// Each access runs grant -> MEM_LAT cycles of mem_en -> one-cycle done pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_t             owner_q, owner_d;
    port_t             last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic  grant;
    port_t winner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= PORT_IF;
            last_q     <= PORT_IF;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        // On a tie the port that did not win last time gets the memory.
        grant  = 1'b0;
        winner = PORT_IF;
        if (d_req && if_req) begin
            grant  = 1'b1;
            winner = (last_q == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            grant  = 1'b1;
            winner = PORT_D;
        end else if (if_req) begin
            grant  = 1'b1;
            winner = PORT_IF;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        d_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_ACCESS;
                    owner_d = winner;
                    last_d  = winner;
                    cnt_d   = CNT_INIT;
                    if (winner == PORT_D) begin
                        addr_d  = d_addr;
                        wr_d    = d_wr;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = if_addr;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                mem_en    = 1'b1;
                mem_wr    = (owner_q == PORT_D) && wr_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (owner_q == PORT_D) begin
                        if (!wr_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if_done = (owner_q == PORT_IF);
                d_done  = (owner_q == PORT_D);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level timing model,
// plus a directed pass on a MEM_LAT=1 instance.
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, mem_en, mem_wr;

    logic        if_req2 = 1'b0, d_req2 = 1'b0, d_wr2 = 1'b0;
    logic [15:0] if_addr2 = '0, d_addr2 = '0, d_wdata2 = '0, mem_rdata2 = '0;
    logic [15:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2;
    logic        if_done2, d_done2, mem_en2, mem_wr2;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_done(if_done2),
        .d_req(d_req2), .d_wr(d_wr2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_rdata(d_rdata2), .d_done(d_done2),
        .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: an access granted at the end of IDLE cycle g occupies g+1..g+L and completes at g+L+1.
    int          cyc = 0;
    bit          busy = 0;
    int          g = 0;
    bit          own = 0;       // 0 = fetch, 1 = data
    bit          last = 0;
    logic [15:0] t_addr = '0, t_wdata = '0;
    bit          t_wr = 0;
    logic [15:0] exp_ird = '0, exp_drd = '0;
    bit          if_pend = 0, d_pend = 0;
    bit          if_dn_prev = 0, d_dn_prev = 0;
    bit          did_mid_rst = 0;

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = 16'($urandom);
        if_pend = 1;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
        d_pend  = 1;
    endtask

    task automatic run_cycle(input int mode);
        bit e_en, e_done, if_dn, d_dn, in_acc;
        @(negedge clk);
        e_en   = busy && (cyc >= g + 1) && (cyc <= g + L);
        e_done = busy && (cyc == g + L + 1);
        if_dn  = e_done && !own;
        d_dn   = e_done && own;
        check_eq("mem_en", 32'(mem_en), 32'(e_en));
        check_eq("mem_wr", 32'(mem_wr), 32'(e_en && own && t_wr));
        check_eq("mem_addr", 32'(mem_addr), e_en ? 32'(t_addr) : 32'd0);
        check_eq("mem_wdata", 32'(mem_wdata), e_en ? 32'(t_wdata) : 32'd0);
        check_eq("if_done", 32'(if_done), 32'(if_dn));
        check_eq("d_done", 32'(d_done), 32'(d_dn));
        check_eq("if_rdata", 32'(if_rdata), 32'(exp_ird));
        check_eq("d_rdata", 32'(d_rdata), 32'(exp_drd));
        if (mode == 1) begin
            if (cyc == 7)  check_eq("tie1_d_done", 32'(d_done), 32'd1);
            if (cyc == 13) check_eq("tie2_if_done", 32'(if_done), 32'd1);
            if (cyc == 19) check_eq("tie3_d_done", 32'(d_done), 32'd1);
            if (cyc == 25) check_eq("tie4_if_done", 32'(if_done), 32'd1);
        end

        mem_rdata = 16'($urandom);
        if (mode == 0) begin
            rst = 1'b0;
            new_if();
            new_d();
        end else if (mode == 1) begin
            rst = 1'b1;
            if (if_dn_prev) new_if();
            if (d_dn_prev) new_d();
        end else begin
            rst = 1'b1;
            if (busy && cyc == g + 2 && cyc > 150 && !did_mid_rst) begin
                rst = 1'b0;
                did_mid_rst = 1;
            end else if (busy && $urandom_range(0, 199) == 0) begin
                rst = 1'b0;
            end
            if (if_dn_prev) begin
                if_pend = 0;
                if_req  = 1'b0;
            end
            if (d_dn_prev) begin
                d_pend = 0;
                d_req  = 1'b0;
            end
            if (!if_pend && $urandom_range(0, 2) == 0) new_if();
            if (!d_pend && $urandom_range(0, 2) == 0) new_d();
            in_acc = busy && (cyc >= g + 1) && (cyc < g + L);
            if (in_acc && !own && $urandom_range(0, 4) == 0) if_addr = 16'($urandom);
            if (in_acc && own && $urandom_range(0, 4) == 0) d_wdata = 16'($urandom);
            if (in_acc && !own && $urandom_range(0, 9) == 0) if_req = 1'b0;
            if (in_acc && own && $urandom_range(0, 9) == 0) d_req = 1'b0;
        end

        if (!rst) begin
            busy    = 0;
            last    = 0;
            exp_ird = '0;
            exp_drd = '0;
            if (!if_req) if_pend = 0;
            if (!d_req) d_pend = 0;
        end else if (busy) begin
            if (cyc == g + L) begin
                if (!own) exp_ird = mem_rdata;
                else if (!t_wr) exp_drd = mem_rdata;
            end
            if (cyc == g + L + 1) busy = 0;
        end else if (if_req || d_req) begin
            if (if_req && d_req) own = !last;
            else own = d_req;
            last = own;
            busy = 1;
            g    = cyc;
            if (own) begin
                t_addr  = d_addr;
                t_wr    = d_wr;
                t_wdata = d_wdata;
            end else begin
                t_addr  = if_addr;
                t_wr    = 0;
                t_wdata = '0;
            end
        end
        if_dn_prev = if_dn && rst;
        d_dn_prev  = d_dn && rst;
        cyc++;
    endtask

    initial begin
        logic [15:0] a, rd;
        rst    = 1'b0;
        if_req = 1'b1;
        d_req  = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle(0);
        for (int i = 2; i < 31; i++) run_cycle(1);
        for (int i = 31; i < 700; i++) run_cycle(2);

        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("l1_idle_en", 32'(mem_en2), 32'd0);
            a          = 16'($urandom);
            d_req2     = 1'b1;
            d_wr2      = 1'b0;
            d_addr2    = a;
            mem_rdata2 = 16'($urandom);
            @(negedge clk);
            check_eq("l1_en", 32'(mem_en2), 32'd1);
            check_eq("l1_addr", 32'(mem_addr2), 32'(a));
            check_eq("l1_early_done", 32'(d_done2), 32'd0);
            rd         = 16'($urandom);
            mem_rdata2 = rd;
            @(negedge clk);
            check_eq("l1_done", 32'(d_done2), 32'd1);
            check_eq("l1_en_off", 32'(mem_en2), 32'd0);
            check_eq("l1_rdata", 32'(d_rdata2), 32'(rd));
            mem_rdata2 = ~rd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
